// File: rtl/div_arbiter_if.sv
// Requester/response bus of the shared-divider arbiter.
// The master side is the requester pool; the slave side is the arbiter.
interface div_arbiter_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_REQ     = 4,
  parameter int ID_W      = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*BIT_WIDTH-1:0] req_a;
  logic [N_REQ*BIT_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [BIT_WIDTH-1:0]       rsp_qu;
  logic [BIT_WIDTH-1:0]       rsp_res;
  logic [1:0]                 rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_qu, rsp_res, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_qu, rsp_res, rsp_err
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N_REQ requesters,
// with divide-by-zero short-circuit and a watchdog that recovers a hung divider.
module div_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int N_REQ     = 4,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int TIMEOUT   = 2*BIT_WIDTH+8
) (
  input  logic                 clk,
  input  logic                 reset,
  div_arbiter_if.slave         bus,
  output logic                 div_start,
  output logic                 div_rst,
  output logic [BIT_WIDTH-1:0] div_a,
  output logic [BIT_WIDTH-1:0] div_b,
  input  logic                 div_done,
  input  logic [BIT_WIDTH-1:0] div_qu,
  input  logic [BIT_WIDTH-1:0] div_res
);

  localparam int WD_W = $clog2(TIMEOUT+1);
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t               state_r;
  logic [ID_W-1:0]      rr_r;
  logic [WD_W-1:0]      wdog_r;
  logic                 div_start_r;
  logic                 div_rst_r;
  logic [BIT_WIDTH-1:0] div_a_r;
  logic [BIT_WIDTH-1:0] div_b_r;
  logic                 rsp_valid_r;
  logic [ID_W-1:0]      rsp_id_r;
  logic [BIT_WIDTH-1:0] rsp_qu_r;
  logic [BIT_WIDTH-1:0] rsp_res_r;
  logic [1:0]           rsp_err_r;

  logic                 gnt_found_s;
  logic [ID_W-1:0]      gnt_idx_s;
  logic [ID_W-1:0]      cand_s;
  logic [BIT_WIDTH-1:0] gnt_a_s;
  logic [BIT_WIDTH-1:0] gnt_b_s;
  logic [N_REQ-1:0]     ready_s;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    if (idx == ID_W'(N_REQ-1)) begin
      return '0;
    end else begin
      return idx + ID_W'(1);
    end
  endfunction

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = rr_r;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found_s && bus.req_valid[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
      cand_s = next_idx(cand_s);
    end
  end

  // Operands of the granted requester and its one-hot accept.
  always_comb begin
    gnt_a_s = bus.req_a[int'(gnt_idx_s)*BIT_WIDTH +: BIT_WIDTH];
    gnt_b_s = bus.req_b[int'(gnt_idx_s)*BIT_WIDTH +: BIT_WIDTH];
    if (state_r == ST_IDLE && !reset && gnt_found_s) begin
      ready_s = N_REQ'(1) << gnt_idx_s;
    end else begin
      ready_s = '0;
    end
  end

  // Arbitration/transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_r        <= '0;
      wdog_r      <= '0;
      div_start_r <= 1'b0;
      div_rst_r   <= 1'b0;
      div_a_r     <= '0;
      div_b_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_qu_r    <= '0;
      rsp_res_r   <= '0;
      rsp_err_r   <= ERR_OK;
    end else begin
      div_start_r <= 1'b0;
      div_rst_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            rsp_id_r <= gnt_idx_s;
            rr_r     <= next_idx(gnt_idx_s);
            // A zero divisor never reaches the divider.
            if (gnt_b_s == '0) begin
              rsp_qu_r    <= '1;
              rsp_res_r   <= gnt_a_s;
              rsp_err_r   <= ERR_DIV0;
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end else begin
              div_a_r     <= gnt_a_s;
              div_b_r     <= gnt_b_s;
              div_start_r <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wdog_r  <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            rsp_qu_r    <= div_qu;
            rsp_res_r   <= div_res;
            rsp_err_r   <= ERR_OK;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (wdog_r == WD_W'(TIMEOUT-1)) begin
            div_rst_r <= 1'b1;
            state_r   <= ST_RECOVER;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        ST_RECOVER: begin
          rsp_qu_r    <= '0;
          rsp_res_r   <= '0;
          rsp_err_r   <= ERR_TIMEOUT;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_qu    = rsp_qu_r;
  assign bus.rsp_res   = rsp_res_r;
  assign bus.rsp_err   = rsp_err_r;
  assign div_start     = div_start_r;
  assign div_rst       = div_rst_r;
  assign div_a         = div_a_r;
  assign div_b         = div_b_r;

endmodule
